alu_pipe: RTL and testbench
===========================

// Module: alu_pipe
//
// PURPOSE
//   Parametrised, pipelined successor to the 4-bit combinational Hack-style ALU.
//   Sits between the operand register file and the writeback/flag logic of the CPU datapath.
//   Applies the zx/nx/zy/ny/f/no control set to WIDTH-bit operands over two registered stages.
//   Reports zr/ng/co flags and uses valid/ready handshakes on both sides with full backpressure.
//
// PARAMETERS
//   WIDTH  16  operand/result width in bits (>= 2)
//
// PORTS
//   clk        in   1      rising-edge clock
//   rst_n      in   1      synchronous reset, active low
//   in_valid   in   1      operand/control beat present
//   in_ready   out  1      block accepts beat this cycle
//   x          in   WIDTH  operand x
//   y          in   WIDTH  operand y
//   ctrl       in   6      {zx,nx,zy,ny,f,no}, bit5 = zx
//   out_valid  out  1      result beat present
//   out_ready  in   1      downstream accepts result
//   result     out  WIDTH  ALU output
//   zr         out  1      result == 0
//   ng         out  1      result[WIDTH-1]
//   co         out  1      carry-out of x'+y' (f=1), else 0
//
// BEHAVIOUR
//   - Reset (rst_n=0 at posedge): s1/s2 valid=0; result, zr, ng, co = 0. in_ready=1 in the cycle after.
//   - Reset mid-operation: in-flight beats are discarded, not completed.
//   - Accept on in_valid & in_ready. Deliver on out_valid & out_ready.
//   - Stage 1 (registered): x' = zx ? 0 : x; x' = nx ? ~x' : x'. Same for y' with zy/ny. Also registers f and no.
//   - Stage 2 (registered): s = f ? x'+y' (WIDTH+1-bit sum) : x'&y'.
//     - result = no ? ~s[WIDTH-1:0] : s[WIDTH-1:0].
//     - co = f & s[WIDTH]; co is not affected by no.
//     - zr and ng are computed from the final result.
//   - Latency: 2 cycles from accept to out_valid with no stall. Throughput: 1 beat/cycle.
//   - Advance rules:
//     - s2 loads when s2 empty or out_ready.
//     - s1 loads when s1 empty or s2 loads.
//     - in_ready = !s1_valid | s2 loads (combinational, no dependency on in_valid).
//   - Stall: with out_ready=0, s2 holds result and flags stable and s1 holds. Once both are full, in_ready=0.
//   - Simultaneous accept and deliver in one cycle is allowed. Ordering is strictly FIFO, with no loss or duplication.
//   - Arithmetic wraps modulo 2^WIDTH. No saturation. No overflow flag.
//   - When out_valid=0, result and flags hold their last value and carry no meaning.
//
// TESTING  (WIDTH=16 unless noted)
//   1. x=0x0005, y=0x0003, ctrl=000010 (x+y) -> result=0x0008, zr=0, ng=0, co=0, out_valid exactly 2 cycles after accept.
//   2. x=0x0005, y=0x0003, ctrl=010011 (x-y) -> 0x0002. ctrl=000111 (y-x) -> 0xFFFE, ng=1.
//   3. ctrl=101010 -> 0x0000, zr=1. ctrl=111010 -> 0xFFFF, ng=1. ctrl=111111 -> 0x0001.
//   4. x=0xFFFF, y=0x0001, ctrl=000010 -> result=0x0000, zr=1, co=1. Same operands with ctrl=000000 (x&y) -> 0x0001, co=0.
//   5. Backpressure: hold out_ready=0 and stream 3 beats (x=1,2,3; x+y with y=0).
//      - in_ready drops after 2 accepts; result stays 0x0001.
//      - Release out_ready -> 1, 2, 3 delivered in order on consecutive cycles.
//   6. Reset mid-operation: rst_n=0 for 1 cycle with both stages full.
//      - Next cycle out_valid=0, result/flags=0, in_ready=1.
//      - Repeat tests 1-4 at WIDTH=4 and WIDTH=32; same values, zero-extended/truncated.

Source files
------------

// File: rtl/alu_pipe_if.sv
// Handshake and data bundle for alu_pipe: operand/control beat in, result/flag beat out.
// Valid/ready: a beat moves on a cycle where valid & ready are both high at the rising edge;
// the producer holds a presented beat stable until it moves, and ready never waits on valid.
interface alu_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [5:0]       ctrl;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zr;
  logic             ng;
  logic             co;
  // Pipeline occupancy {s2_valid, s1_valid}, exported for checkers.
  logic [1:0]       dbg_occ;

  modport master (
    output in_valid, x, y, ctrl, out_ready,
    input  in_ready, out_valid, result, zr, ng, co, dbg_occ
  );

  modport slave (
    input  in_valid, x, y, ctrl, out_ready,
    output in_ready, out_valid, result, zr, ng, co, dbg_occ
  );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage pipelined Hack-style ALU: stage 1 conditions the operands, stage 2 computes
// the result and zr/ng/co flags. Both stages stall under output backpressure.
module alu_pipe #(
  parameter int WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_pipe_if.slave  bus
);

  // Stage 1 registers: conditioned operands plus the function/negate-output bits.
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_x_q, s1_x_d;
  logic [WIDTH-1:0] s1_y_q, s1_y_d;
  logic             s1_f_q, s1_f_d;
  logic             s1_no_q, s1_no_d;

  // Stage 2 registers: the delivered result and its flags.
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zr_q, zr_d;
  logic             ng_q, ng_d;
  logic             co_q, co_d;

  logic             s2_load;
  logic             s1_load;
  logic             accept;

  logic             zx, nx, zy, ny, fn, no;
  logic [WIDTH-1:0] x_cond, y_cond;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] s_low;
  logic [WIDTH-1:0] res_next;

  assign {zx, nx, zy, ny, fn, no} = bus.ctrl;

  // A stage advances when it is empty or its consumer takes its content this cycle.
  assign s2_load = !s2_valid_q || bus.out_ready;
  assign s1_load = !s1_valid_q || s2_load;
  assign accept  = bus.in_valid && s1_load;

  always_comb begin
    x_cond = zx ? '0 : bus.x;
    x_cond = nx ? ~x_cond : x_cond;
    y_cond = zy ? '0 : bus.y;
    y_cond = ny ? ~y_cond : y_cond;
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_x_d     = s1_x_q;
    s1_y_d     = s1_y_q;
    s1_f_d     = s1_f_q;
    s1_no_d    = s1_no_q;
    if (s1_load) begin
      s1_valid_d = accept;
    end
    if (accept) begin
      s1_x_d  = x_cond;
      s1_y_d  = y_cond;
      s1_f_d  = fn;
      s1_no_d = no;
    end
  end

  // Carry is taken from the raw sum so the output negation cannot disturb it.
  always_comb begin
    sum      = {1'b0, s1_x_q} + {1'b0, s1_y_q};
    s_low    = s1_f_q ? sum[WIDTH-1:0] : (s1_x_q & s1_y_q);
    res_next = s1_no_q ? ~s_low : s_low;
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    result_d   = result_q;
    zr_d       = zr_q;
    ng_d       = ng_q;
    co_d       = co_q;
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        result_d = res_next;
        zr_d     = (res_next == '0);
        ng_d     = res_next[WIDTH-1];
        co_d     = s1_f_q & sum[WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      s1_f_q     <= 1'b0;
      s1_no_q    <= 1'b0;
      s2_valid_q <= 1'b0;
      result_q   <= '0;
      zr_q       <= 1'b0;
      ng_q       <= 1'b0;
      co_q       <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_x_q     <= s1_x_d;
      s1_y_q     <= s1_y_d;
      s1_f_q     <= s1_f_d;
      s1_no_q    <= s1_no_d;
      s2_valid_q <= s2_valid_d;
      result_q   <= result_d;
      zr_q       <= zr_d;
      ng_q       <= ng_d;
      co_q       <= co_d;
    end
  end

  assign bus.in_ready  = s1_load;
  assign bus.out_valid = s2_valid_q;
  assign bus.result    = result_q;
  assign bus.zr        = zr_q;
  assign bus.ng        = ng_q;
  assign bus.co        = co_q;
  assign bus.dbg_occ   = {s2_valid_q, s1_valid_q};

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe at WIDTH=16, 4 and 32 driven from one shared stimulus.
module tb_alu_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] x;
  logic [31:0] y;
  logic [5:0]  ctrl;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  alu_pipe_if #(.WIDTH(16)) b16 ();
  alu_pipe_if #(.WIDTH(4))  b4 ();
  alu_pipe_if #(.WIDTH(32)) b32 ();

  assign b16.in_valid = in_valid;
  assign b16.x        = x[15:0];
  assign b16.y        = y[15:0];
  assign b16.ctrl     = ctrl;
  assign b16.out_ready = out_ready;
  assign b4.in_valid  = in_valid;
  assign b4.x         = x[3:0];
  assign b4.y         = y[3:0];
  assign b4.ctrl      = ctrl;
  assign b4.out_ready = out_ready;
  assign b32.in_valid = in_valid;
  assign b32.x        = x;
  assign b32.y        = y;
  assign b32.ctrl     = ctrl;
  assign b32.out_ready = out_ready;

  alu_pipe #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));
  alu_pipe #(.WIDTH(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(b4));
  alu_pipe #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver: one isolated beat through all three widths; flags packed {zr,ng,co}.
  task automatic run_op(input string tag, input logic [31:0] xv, input logic [31:0] yv,
                        input logic [5:0] c,
                        input logic [31:0] r16, input logic [2:0] f16,
                        input logic [31:0] r4,  input logic [2:0] f4,
                        input logic [31:0] r32, input logic [2:0] f32);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    x = xv; y = yv; ctrl = c;
    chk({tag, "_in_ready"}, {31'b0, b16.in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk({tag, "_ov_early"}, {31'b0, b16.out_valid}, 32'd0);
    tick();
    chk({tag, "_ov16"}, {31'b0, b16.out_valid}, 32'd1);
    chk({tag, "_res16"}, {16'b0, b16.result}, r16);
    chk({tag, "_flg16"}, {29'b0, b16.zr, b16.ng, b16.co}, {29'b0, f16});
    chk({tag, "_ov4"}, {31'b0, b4.out_valid}, 32'd1);
    chk({tag, "_res4"}, {28'b0, b4.result}, r4);
    chk({tag, "_flg4"}, {29'b0, b4.zr, b4.ng, b4.co}, {29'b0, f4});
    chk({tag, "_ov32"}, {31'b0, b32.out_valid}, 32'd1);
    chk({tag, "_res32"}, b32.result, r32);
    chk({tag, "_flg32"}, {29'b0, b32.zr, b32.ng, b32.co}, {29'b0, f32});
    tick();
    chk({tag, "_ov_after"}, {31'b0, b16.out_valid}, 32'd0);
  endtask

  initial begin
    int sent;
    int got;
    logic acc;
    logic [31:0] expv;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    x = '0; y = '0; ctrl = '0;
    tick(); tick();
    rst_n = 1'b1;
    chk("rst_out_valid", {31'b0, b16.out_valid}, 32'd0);
    chk("rst_result", {16'b0, b16.result}, 32'd0);
    chk("rst_flags", {29'b0, b16.zr, b16.ng, b16.co}, 32'd0);
    chk("rst_in_ready", {31'b0, b16.in_ready}, 32'd1);
    chk("rst_occ", {30'b0, b16.dbg_occ}, 32'd0);

    // Tests 1-4 across widths
    run_op("add",   32'h5, 32'h3, 6'b000010, 32'h8, 3'b000, 32'h8, 3'b010, 32'h8, 3'b000);
    run_op("x_m_y", 32'h5, 32'h3, 6'b010011, 32'h2, 3'b000, 32'h2, 3'b000, 32'h2, 3'b000);
    run_op("y_m_x", 32'h5, 32'h3, 6'b000111, 32'hFFFE, 3'b011, 32'hE, 3'b011,
           32'hFFFF_FFFE, 3'b011);
    run_op("zero",  32'h5, 32'h3, 6'b101010, 32'h0, 3'b100, 32'h0, 3'b100, 32'h0, 3'b100);
    run_op("m_one", 32'h5, 32'h3, 6'b111010, 32'hFFFF, 3'b010, 32'hF, 3'b010,
           32'hFFFF_FFFF, 3'b010);
    run_op("one",   32'h5, 32'h3, 6'b111111, 32'h1, 3'b001, 32'h1, 3'b001, 32'h1, 3'b001);
    run_op("wrap",  32'hFFFF, 32'h1, 6'b000010, 32'h0, 3'b101, 32'h0, 3'b101,
           32'h0001_0000, 3'b000);
    run_op("and",   32'hFFFF, 32'h1, 6'b000000, 32'h1, 3'b000, 32'h1, 3'b000, 32'h1, 3'b000);

    // Test 5: backpressure with three beats
    out_ready = 1'b0;
    in_valid = 1'b1; y = 32'h0; ctrl = 6'b000010;
    x = 32'h1;
    tick();
    x = 32'h2;
    chk("bp_in_ready_2nd", {31'b0, b16.in_ready}, 32'd1);
    tick();
    x = 32'h3;
    chk("bp_in_ready_low", {31'b0, b16.in_ready}, 32'd0);
    chk("bp_ov", {31'b0, b16.out_valid}, 32'd1);
    chk("bp_res_hold0", {16'b0, b16.result}, 32'h1);
    tick(); tick();
    chk("bp_in_ready_still_low", {31'b0, b16.in_ready}, 32'd0);
    chk("bp_res_hold1", {16'b0, b16.result}, 32'h1);
    chk("bp_occ_full", {30'b0, b16.dbg_occ}, 32'd3);
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", {31'b0, b16.in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_d2_ov", {31'b0, b16.out_valid}, 32'd1);
    chk("bp_d2_res", {16'b0, b16.result}, 32'h2);
    tick();
    chk("bp_d3_ov", {31'b0, b16.out_valid}, 32'd1);
    chk("bp_d3_res", {16'b0, b16.result}, 32'h3);
    tick();
    chk("bp_drained", {31'b0, b16.out_valid}, 32'd0);

    // Test 6: reset with both stages full
    out_ready = 1'b0;
    in_valid = 1'b1; x = 32'h7; y = 32'h1; ctrl = 6'b000111;
    tick();
    x = 32'h9;
    tick();
    in_valid = 1'b0;
    chk("rm_full", {30'b0, b16.dbg_occ}, 32'd3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rm_ov", {31'b0, b16.out_valid}, 32'd0);
    chk("rm_res", {16'b0, b16.result}, 32'h0);
    chk("rm_flags", {29'b0, b16.zr, b16.ng, b16.co}, 32'd0);
    chk("rm_in_ready", {31'b0, b16.in_ready}, 32'd1);
    out_ready = 1'b1;
    tick(); tick();
    chk("rm_no_stale", {31'b0, b16.out_valid}, 32'd0);

    // Back-to-back stream scoreboard: beat k is x=3k, y=k, x+y -> 4k
    exp_q.delete();
    sent = 0; got = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (sent < 5) begin
        in_valid = 1'b1; x = 32'(sent * 3); y = 32'(sent); ctrl = 6'b000010;
      end else begin
        in_valid = 1'b0;
      end
      acc = in_valid && b16.in_ready;
      @(posedge clk);
      if (acc) begin
        exp_q.push_back(32'(sent * 4));
        sent++;
      end
      #1;
      if (b16.out_valid) begin
        if (exp_q.size() == 0) begin
          chk("stream_extra_beat", {16'b0, b16.result}, 32'hDEAD_BEEF);
        end else begin
          expv = exp_q.pop_front();
          chk("stream_beat", {16'b0, b16.result}, expv);
        end
        got++;
      end
    end
    in_valid = 1'b0;
    chk("stream_count", 32'(got), 32'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
